sixteenbit_serial_sub: RTL and testbench
========================================

SIXTEENBIT_SERIAL_SUB -- requirements
Module: sixteenbit_serial_sub

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 start  input  1  request to begin a subtraction; sampled each rising edge.
REQ-005 X  input  16  minuend; sampled only on the edge a start is accepted.
REQ-006 Y  input  16  subtrahend; sampled only on the edge a start is accepted.
REQ-007 Bin  input  1  borrow-in; sampled only on the edge a start is accepted.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse marking Diff/Bout updated.
REQ-010 Diff  output  16  registered result X - Y - Bin, modulo 2^16.
REQ-011 Bout  output  1  registered borrow-out; 1 iff X < Y + Bin as unsigned integers.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-013 A start SHALL be accepted only when busy=0, i.e. in IDLE or DONE.
- On acceptance, latch X, Y and Bin.
- Clear the 2-bit nibble counter to 0.
- Set the internal carry to ~Bin.
- Go to RUN.
REQ-014 start while in RUN SHALL be ignored, with no effect on the latched operands or the count.
REQ-015 Each RUN cycle SHALL compute one 4-bit nibble k = counter, from bit 0 upward.
- {c, d} = X[4k+3:4k] + ~Y[4k+3:4k] + carry.
- d goes to the internal result nibble k.
- c becomes the next carry.
REQ-016 The counter SHALL increment once per RUN cycle; after nibble 3, the FSM SHALL go to DONE.
REQ-017 On the RUN-to-DONE edge, the following SHALL update simultaneously:
- Diff loads the full internal result.
- Bout loads ~(final carry).
REQ-018 Diff and Bout SHALL hold their previous values during RUN and SHALL stay stable until the next completion.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE (one cycle).
REQ-020 DONE SHALL go to IDLE on the next edge when no start is present, and to RUN when start is present.
- This gives back-to-back operation with a 5-cycle issue interval.
REQ-021 Latency: start accepted at edge N gives busy=1 after edges N..N+3, and done=1 with valid Diff/Bout after edge N+4.
REQ-022 Operand changes on X, Y or Bin after acceptance SHALL NOT affect the running result.
REQ-023 Arithmetic SHALL be unsigned 16-bit, with no saturation.
- Diff wraps modulo 2^16.
- The true borrow is reported only through Bout.

Reset
REQ-024 When rst=1, the following SHALL all be 0 after the edge:
- FSM state = IDLE
- busy, done, Diff, Bout
- counter, internal carry, internal result
REQ-025 rst SHALL take priority over start and over any state transition, including mid-RUN.
- A reset during RUN abandons the operation.
- A reset during RUN does not update Diff/Bout except by clearing them.
REQ-026 start asserted together with rst SHALL be ignored; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-027 Simple subtraction: X=0x0005, Y=0x0003, Bin=0, start for one cycle.
- Exactly 4 cycles of busy=1.
- Then done=1 for one cycle with Diff=0x0002, Bout=0.
REQ-028 Underflow: X=0x0000, Y=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1.
REQ-029 Borrow ripples across all nibbles: X=0x1000, Y=0x0001, Bin=0 -> Diff=0x0FFF, Bout=0.
REQ-030 Borrow-in: X=0x1234, Y=0x1234, Bin=1 -> Diff=0xFFFF, Bout=1.
REQ-031 Ignored start and input isolation:
- Start X=0x8000, Y=0x0001.
- During RUN, pulse start with X=0xFFFF, Y=0xFFFF.
- Required: a single result, Diff=0x7FFF, Bout=0.
REQ-032 Reset mid-operation, then back-to-back:
- rst asserted on the 2nd RUN cycle -> next cycle all outputs 0, busy=0.
- Then start X=0x00FF, Y=0x000F -> Diff=0x00F0.
- A start held during that done cycle (X=0x0010, Y=0x0020) is accepted, with no idle cycle.
- That second operation gives Diff=0xFFF0, Bout=1.

Source files
------------

// File: rtl/sixteenbit_serial_sub.sv
// sixteenbit_serial_sub: 16-bit unsigned subtractor that walks the operands
// one nibble per clock (LSB nibble first) using X + ~Y + carry, with the
// carry seeded by ~Bin. Results land in Diff/Bout in the same edge that
// leaves RUN. The operands are captured once at start, so later changes on
// X/Y/Bin do not reach a running operation.
module sixteenbit_serial_sub (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic        Bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] Diff,
    output logic        Bout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic        carry_r;
    logic [15:0] x_r;
    logic [15:0] y_r;
    logic [15:0] res_r;

    logic [3:0]  x_nib_s;
    logic [3:0]  y_nib_s;
    logic [4:0]  sum_s;
    logic [15:0] res_next_s;
    logic        last_nib_s;

    // Pick nibble k of a 16-bit word; an out-of-range index yields zero.
    function automatic logic [3:0] get_nibble(input logic [15:0] word, input logic [1:0] k);
        logic [3:0] nib;
        case (k)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            2'd3:    nib = word[15:12];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // Replace nibble k of a 16-bit word with a new value.
    function automatic logic [15:0] put_nibble(input logic [15:0] word, input logic [1:0] k,
                                               input logic [3:0] nib);
        logic [15:0] w;
        w = word;
        case (k)
            2'd0:    w[3:0]   = nib;
            2'd1:    w[7:4]   = nib;
            2'd2:    w[11:8]  = nib;
            2'd3:    w[15:12] = nib;
            default: w = word;
        endcase
        return w;
    endfunction

    // One nibble of X + ~Y + carry for the current count, and the result
    // word as it will look once that nibble is written back.
    always_comb begin
        x_nib_s    = get_nibble(x_r, cnt_r);
        y_nib_s    = get_nibble(y_r, cnt_r);
        sum_s      = {1'b0, x_nib_s} + {1'b0, ~y_nib_s} + {4'b0000, carry_r};
        res_next_s = put_nibble(res_r, cnt_r, sum_s[3:0]);
        if (cnt_r == 2'd3) begin
            last_nib_s = 1'b1;
        end else begin
            last_nib_s = 1'b0;
        end
    end

    // Control FSM plus datapath registers; busy/done are registered so they
    // track the state exactly (busy in RUN, done in DONE).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
            carry_r <= 1'b0;
            x_r     <= 16'h0000;
            y_r     <= 16'h0000;
            res_r   <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
            Diff    <= 16'h0000;
            Bout    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_r     <= X;
                        y_r     <= Y;
                        carry_r <= ~Bin;
                        cnt_r   <= 2'd0;
                        state_r <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    res_r   <= res_next_s;
                    carry_r <= sum_s[4];
                    cnt_r   <= cnt_r + 2'd1;
                    if (last_nib_s) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        Diff    <= res_next_s;
                        Bout    <= ~sum_s[4];
                    end else begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sixteenbit_serial_sub.sv
// Self-checking bench for sixteenbit_serial_sub: directed vector table,
// randomized back-to-back operations against an arithmetic model, and
// hand sequences for ignored start, reset mid-run and back-to-back issue.
module tb_sixteenbit_serial_sub;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;

    int n_tests;
    int n_fail;

    // Last completed result as the model sees it; Diff/Bout must hold it during RUN.
    logic [15:0] held_diff;
    logic        held_bout;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        bin;
        logic [15:0] exp_diff;
        logic        exp_bout;
    } vec_t;

    vec_t vecs[6];

    sixteenbit_serial_sub dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (x),
        .Y     (y),
        .Bin   (bin),
        .busy  (busy),
        .done  (done),
        .Diff  (diff),
        .Bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer subtraction.
    function automatic logic [15:0] model_diff(input logic [15:0] a, input logic [15:0] b, input logic c);
        int unsigned r;
        r = 32'(a) - 32'(b) - 32'(c);
        return r[15:0];
    endfunction

    function automatic logic model_bout(input logic [15:0] a, input logic [15:0] b, input logic c);
        return (32'(a) < (32'(b) + 32'(c)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start request; the next rising edge is the one that accepts it.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c);
        start = 1'b1;
        x     = a;
        y     = b;
        bin   = c;
    endtask

    // Accept edge, four RUN cycles with the operand inputs scrambled, then done.
    task automatic finish_op(input string name, input logic [15:0] ed, input logic eb);
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({name, " busy"}, {31'd0, busy}, 32'd1);
            check({name, " done low"}, {31'd0, done}, 32'd0);
            check({name, " diff hold"}, {16'd0, diff}, {16'd0, held_diff});
            check({name, " bout hold"}, {31'd0, bout}, {31'd0, held_bout});
            x   = 16'($urandom());
            y   = 16'($urandom());
            bin = 1'($urandom());
            step();
        end
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " busy low"}, {31'd0, busy}, 32'd0);
        check({name, " diff"}, {16'd0, diff}, {16'd0, ed});
        check({name, " bout"}, {31'd0, bout}, {31'd0, eb});
        held_diff = ed;
        held_bout = eb;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        held_diff = 16'h0000;
        held_bout = 1'b0;
        rst       = 1'b1;
        start     = 1'b1;
        x         = 16'hFFFF;
        y         = 16'h0001;
        bin       = 1'b1;

        vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        vecs[2] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
        vecs[3] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};

        // Reset with start held: start must be ignored.
        step();
        step();
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst diff", {16'd0, diff}, 32'd0);
        check("rst bout", {31'd0, bout}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("idle busy", {31'd0, busy}, 32'd0);

        // Directed table, each op isolated by one idle cycle.
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].x, vecs[i].y, vecs[i].bin);
            finish_op($sformatf("vec%0d", i), vecs[i].exp_diff, vecs[i].exp_bout);
            step();
            check($sformatf("vec%0d single done", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d idle", i), {31'd0, busy}, 32'd0);
        end

        // Randomized back-to-back operations (start held in each done cycle).
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic        c;
            a = 16'($urandom());
            b = 16'($urandom());
            c = 1'($urandom());
            if (i % 8 == 0) begin
                b = a;
            end else begin
                b = b;
            end
            issue(a, b, c);
            finish_op($sformatf("rnd%0d", i), model_diff(a, b, c), model_bout(a, b, c));
        end
        step();

        // Start pulses with new operands during RUN are ignored.
        issue(16'h8000, 16'h0001, 1'b0);
        step();
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        check("ign busy0", {31'd0, busy}, 32'd1);
        step();
        check("ign busy1", {31'd0, busy}, 32'd1);
        step();
        start = 1'b0;
        check("ign busy2", {31'd0, busy}, 32'd1);
        step();
        check("ign busy3", {31'd0, busy}, 32'd1);
        step();
        check("ign done", {31'd0, done}, 32'd1);
        check("ign diff", {16'd0, diff}, 32'h7FFF);
        check("ign bout", {31'd0, bout}, 32'd0);
        held_diff = 16'h7FFF;
        held_bout = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("ign no 2nd done", {31'd0, done}, 32'd0);
            check("ign no 2nd busy", {31'd0, busy}, 32'd0);
        end

        // Reset on the 2nd RUN cycle abandons the operation.
        issue(16'h4444, 16'h1111, 1'b0);
        step();
        start = 1'b0;
        step();
        check("mid busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst done", {31'd0, done}, 32'd0);
        check("mid rst diff", {16'd0, diff}, 32'd0);
        check("mid rst bout", {31'd0, bout}, 32'd0);
        held_diff = 16'h0000;
        held_bout = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mid abandoned done", {31'd0, done}, 32'd0);
            check("mid abandoned diff", {16'd0, diff}, 32'd0);
        end

        // Back-to-back with no idle cycle between.
        issue(16'h00FF, 16'h000F, 1'b0);
        finish_op("b2b first", 16'h00F0, 1'b0);
        issue(16'h0010, 16'h0020, 1'b0);
        finish_op("b2b second", 16'hFFF0, 1'b1);
        step();
        check("b2b end done", {31'd0, done}, 32'd0);
        check("b2b end busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
